// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default register-specifier width and the hard-wired zero register.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;

  // Register 0 is hard-wired to zero and never creates a true dependency.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_det.sv
// Load-use detector: flags an ID instruction that reads the destination of a
// load currently in EX. Purely combinational.
module load_use_det
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  lu
);

  logic rd_nonzero;
  logic rs_match;
  logic rt_match;

  // Compare the load destination against both ID source operands.
  always_comb begin
    rd_nonzero = (ex_rd != REG_ADDR_W'(REG_ZERO));
    rs_match   = (ex_rd == id_rs);
    rt_match   = id_uses_rt & (ex_rd == id_rt);
    lu         = ex_memread & rd_nonzero & (rs_match | rt_match);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for the 5-stage CPU: load-use bubbles,
// multi-cycle EX stall FSM and MEM-resolved branch flushes.
// Optional macro HAZ_PERF_CNT_EN adds saturating stall/flush perf counters.
module hazard_stall_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mc_valid_i,
  input  logic                  mem_branch_taken_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  id_ex_write_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_flush_o,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
`endif
  output logic                  state_o
);

  localparam int MCW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [MCW-1:0] MC_LOAD = MCW'(MC_LAT - 2);

  // Elaboration-time guard: a multi-cycle op must occupy EX at least 2 cycles.
  if (MC_LAT < 2 || CNT_W < 1) begin : g_bad_param
    $error("hazard_stall_ctrl: MC_LAT must be >= 2 and CNT_W >= 1");
  end

  state_t         state;
  state_t         state_nxt;
  logic [MCW-1:0] mc_cnt;
  logic [MCW-1:0] mc_cnt_nxt;
  logic           lu;

  load_use_det #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lu (
    .id_rs      (id_rs_i),
    .id_rt      (id_rt_i),
    .id_uses_rt (id_uses_rt_i),
    .ex_memread (ex_memread_i),
    .ex_rd      (ex_rd_i),
    .lu         (lu)
  );

  // Prioritised hazard resolution: branch flush, MC stall, MC release, load-use.
  always_comb begin
    state_nxt      = state;
    mc_cnt_nxt     = mc_cnt;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    if (mem_branch_taken_i) begin
      // Younger stages are wrong-path; any in-flight MC op is aborted.
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      state_nxt      = ST_RUN;
      mc_cnt_nxt     = '0;
    end else if (state == ST_RUN && ex_mc_valid_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_write_o  = 1'b0;
      ex_mem_flush_o = 1'b1;
      state_nxt      = ST_MC_BUSY;
      mc_cnt_nxt     = MC_LOAD;
    end else if (state == ST_MC_BUSY && mc_cnt != '0) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_write_o  = 1'b0;
      ex_mem_flush_o = 1'b1;
      mc_cnt_nxt     = mc_cnt - MCW'(1);
    end else if (state == ST_MC_BUSY) begin
      // Release cycle: op finishes its last EX cycle with default outputs.
      state_nxt      = ST_RUN;
    end else if (lu) begin
      // One bubble; the load reaches MEM next cycle, clearing the hazard.
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_flush_o  = 1'b1;
    end else begin
      state_nxt      = state;
    end
    if (!rst_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_write_o  = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_flush_o = 1'b0;
    end else begin
      ex_mem_flush_o = ex_mem_flush_o;
    end
  end

  assign state_o = rst_i ? logic'(state) : 1'b0;

  // Stall FSM state and multi-cycle down-counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_RUN;
      mc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating counters of stall cycles and branch flush cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_write_o && stall_cnt_o != '1) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (mem_branch_taken_i && flush_cnt_o != '1) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller for the 5-stage CPU. It drives the write-enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three hazards:
- load-use hazards, by inserting a 1-cycle bubble;
- multi-cycle EX operations (mult/div), by running a down-counter stall FSM;
- taken branches resolved in MEM, by flushing the three younger stages.

Parameters:
REG_ADDR_W, 5, register-specifier width
MC_LAT, 4, cycles a multi-cycle op occupies EX (legal range >= 2)
CNT_W, 32, perf-counter width (used only with HAZ_PERF_CNT_EN)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
id_rs_i  in  REG_ADDR_W  rs of the instruction in ID
id_rt_i  in  REG_ADDR_W  rt of the instruction in ID
id_uses_rt_i  in  1  ID instruction reads rt
ex_memread_i  in  1  EX instruction is a load
ex_rd_i  in  REG_ADDR_W  destination register of the EX instruction
ex_mc_valid_i  in  1  EX holds a multi-cycle op
mem_branch_taken_i  in  1  taken branch/jump resolved in MEM
pc_write_o  out  1  PC write enable
if_id_write_o  out  1  IF/ID write enable
id_ex_write_o  out  1  ID/EX write enable
if_id_flush_o  out  1  IF/ID flush
id_ex_flush_o  out  1  ID/EX flush (bubble)
ex_mem_flush_o  out  1  EX/MEM flush (bubble)
state_o  out  1  0 = RUN, 1 = MC_BUSY

Behaviour:
- State and counter:
  - States are RUN and MC_BUSY. mc_cnt is a down-counter of width clog2(MC_LAT).
  - Reset (rst_i = 0, asynchronous): state = RUN, mc_cnt = 0.
  - While rst_i = 0, all write and flush outputs are 0 and state_o = 0.
- Outputs are combinational from state, mc_cnt and the inputs. Default in RUN with no hazard: all writes = 1, all flushes = 0.
- Load-use hazard (lu): ex_memread_i & (ex_rd_i != 0) & ((ex_rd_i == id_rs_i) | (id_uses_rt_i & (ex_rd_i == id_rt_i))).
- Priority, highest first:
  1. mem_branch_taken_i = 1:
     - if_id_flush_o = id_ex_flush_o = ex_mem_flush_o = 1; all writes = 1.
     - Next state = RUN, mc_cnt = 0. An in-flight multi-cycle op is wrong-path and is aborted.
  2. RUN & ex_mc_valid_i:
     - pc_write_o = if_id_write_o = id_ex_write_o = 0; ex_mem_flush_o = 1.
     - Next state = MC_BUSY, mc_cnt = MC_LAT-2.
  3. MC_BUSY & mc_cnt != 0:
     - Same stall outputs as item 2; mc_cnt decrements.
  4. MC_BUSY & mc_cnt == 0:
     - Stall released (default outputs); next state = RUN.
     - Total stall = MC_LAT-1 cycles; the op spends MC_LAT cycles in EX.
  5. RUN & lu:
     - pc_write_o = if_id_write_o = 0; id_ex_flush_o = 1. Exactly 1 bubble.
     - No state change: the load has moved to MEM on the next cycle.
- Boundary rules:
  - lu is ignored in MC_BUSY, because EX is frozen.
  - Back-to-back multi-cycle ops: after the release cycle, the next op entering EX re-triggers item 2 in RUN.
  - Branch and lu in the same cycle: the flush wins and pc_write_o = 1.
  - Register 0 never causes a load-use stall.
  - MC_LAT < 2 is illegal; the block fires a simulation assertion at time 0.

Optional Feature:
HAZ_PERF_CNT_EN:
- When defined, adds output ports stall_cnt_o [CNT_W] and flush_cnt_o [CNT_W].
  - stall_cnt_o increments on every cycle with pc_write_o = 0 and rst_i = 1.
  - flush_cnt_o increments on every cycle with mem_branch_taken_i = 1.
  - Both counters saturate at all-ones and reset to 0.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package hazard_ctrl_pkg:
  - state encoding ST_RUN = 1'b0, ST_MC_BUSY = 1'b1;
  - REG_ADDR_W default;
  - zero-register constant REG_ZERO.
- Sub-module load_use_det: purely combinational lu compare (id_rs, id_rt, id_uses_rt, ex_memread, ex_rd -> lu). The FSM, counter and output mux stay in the top module.

Test Plan:
- Reset: hold rst_i = 0 for 3 cycles with random inputs -> all outputs 0 and state_o = 0; after release with idle inputs -> writes = 1, flushes = 0.
- Load-use: ex_memread_i = 1, ex_rd_i = 8, id_rs_i = 8 -> exactly 1 cycle with pc_write_o = 0, if_id_write_o = 0, id_ex_flush_o = 1. Repeat with ex_rd_i = 0 -> no stall. Repeat with the match on rt only and id_uses_rt_i = 0 -> no stall.
- Multi-cycle op, MC_LAT = 4: pulse ex_mc_valid_i = 1 -> pc_write_o = 0 for 3 consecutive cycles, ex_mem_flush_o = 1 during those cycles, state_o = 1 for 2 of them, then default outputs.
- Branch aborts multi-cycle: assert mem_branch_taken_i in the 2nd stall cycle -> same cycle all three flushes = 1 and pc_write_o = 1; next cycle state_o = 0 with no residual stall.
- Branch and lu in the same cycle -> flushes = 1, pc_write_o = 1, no bubble-only response.
- With HAZ_PERF_CNT_EN defined and CNT_W = 2: 5 load-use stalls -> stall_cnt_o saturates at 3; 2 branches -> flush_cnt_o = 2.
